// File: rtl/snake_if.sv
// Write-port and control bundle between the snake engine and its controller/world memory.
interface snake_if;
    logic       tick;
    logic [1:0] dir_in;
    logic [1:0] data_in;
    logic [4:0] x_loc_sw;
    logic [4:0] y_loc_sw;
    logic       writeEnable;
    logic [7:0] score;
    logic       game_over;
    logic       busy;

    modport master (
        output tick, dir_in,
        input  data_in, x_loc_sw, y_loc_sw, writeEnable, score, game_over, busy
    );

    modport slave (
        input  tick, dir_in,
        output data_in, x_loc_sw, y_loc_sw, writeEnable, score, game_over, busy
    );
endinterface

// File: rtl/snake_engine.sv
// Snake game logic: advances the body on each tick and emits single-cycle cell writes.
// Non-eat move of length L takes L+2 cycles; ticks outside IDLE are dropped.
module snake_engine #(
    parameter int         MAX_LEN   = 32,
    parameter int         INIT_LEN  = 3,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic    clk,
    input  logic    rst,
    snake_if.slave  bus
);
    localparam int PW = $clog2(MAX_LEN);
    localparam logic [PW:0] LEN_MAX = (PW+1)'(MAX_LEN);

    typedef enum logic [3:0] {
        IDLE, COMPUTE, SCAN, ERASE_TAIL, WRITE_HEAD,
        FOOD_PICK, FOOD_SCAN, FOOD_WRITE, DEAD
    } state_t;

    state_t        state;
    logic [3:0]    body_x [MAX_LEN];
    logic [3:0]    body_y [MAX_LEN];
    logic [PW-1:0] tail_ptr, head_ptr, scan_ptr;
    logic [PW:0]   len;
    logic [1:0]    dir, dir_req, mv_dir;
    logic [3:0]    head_x, head_y, food_x, food_y, cand_x, cand_y;
    logic          eat, hit;
    logic [7:0]    lfsr;
    logic [4:0]    nx, ny;
    logic          wall, hit_c, eat_c, body_hit, cand_hit;

    always_comb begin
        mv_dir = (dir_req == (dir ^ 2'b10)) ? dir : dir_req;
        nx = {1'b0, body_x[head_ptr]};
        ny = {1'b0, body_y[head_ptr]};
        case (mv_dir)
            2'd0:    ny = ny - 5'd1;
            2'd1:    nx = nx + 5'd1;
            2'd2:    ny = ny + 5'd1;
            default: nx = nx - 5'd1;
        endcase
        wall     = (nx == 5'd0) || (nx == 5'd16) || (ny == 5'd0) || (ny == 5'd16);
        hit_c    = (nx[3:0] == food_x) && (ny[3:0] == food_y);
        eat_c    = hit_c && (len < LEN_MAX);
        body_hit = (body_x[scan_ptr] == head_x) && (body_y[scan_ptr] == head_y);
        cand_hit = (body_x[scan_ptr] == cand_x) && (body_y[scan_ptr] == cand_y);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            for (int i = 0; i < MAX_LEN; i++) begin
                body_x[i] <= (i < INIT_LEN) ? 4'(i + 1) : 4'd0;
                body_y[i] <= (i < INIT_LEN) ? 4'd1 : 4'd0;
            end
            tail_ptr        <= '0;
            head_ptr        <= PW'(INIT_LEN - 1);
            scan_ptr        <= '0;
            len             <= (PW+1)'(INIT_LEN);
            dir             <= 2'd1;
            dir_req         <= 2'd1;
            head_x          <= 4'd0;
            head_y          <= 4'd0;
            food_x          <= 4'd11;
            food_y          <= 4'd4;
            cand_x          <= 4'd0;
            cand_y          <= 4'd0;
            eat             <= 1'b0;
            hit             <= 1'b0;
            lfsr            <= LFSR_SEED;
            bus.writeEnable <= 1'b0;
            bus.data_in     <= 2'd0;
            bus.x_loc_sw    <= 5'd0;
            bus.y_loc_sw    <= 5'd0;
            bus.score       <= 8'd0;
            bus.game_over   <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            lfsr            <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            bus.writeEnable <= 1'b0;
            case (state)
                IDLE: if (bus.tick && !bus.game_over) begin
                    dir_req  <= bus.dir_in;
                    bus.busy <= 1'b1;
                    state    <= COMPUTE;
                end
                COMPUTE: begin
                    dir <= mv_dir;
                    if (wall) begin
                        bus.game_over <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= DEAD;
                    end else begin
                        head_x   <= nx[3:0];
                        head_y   <= ny[3:0];
                        hit      <= hit_c;
                        eat      <= eat_c;
                        // Growing keeps the tail cell occupied, so it must be checked too.
                        scan_ptr <= eat_c ? tail_ptr : tail_ptr + 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (body_hit) begin
                        bus.game_over <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= DEAD;
                    end else if (scan_ptr == head_ptr) begin
                        // Write strobes are set up one cycle early so they align with the state.
                        bus.writeEnable <= 1'b1;
                        if (eat) begin
                            bus.data_in  <= 2'b10;
                            bus.x_loc_sw <= {1'b0, head_x};
                            bus.y_loc_sw <= {1'b0, head_y};
                            state        <= WRITE_HEAD;
                        end else begin
                            bus.data_in  <= 2'b00;
                            bus.x_loc_sw <= {1'b0, body_x[tail_ptr]};
                            bus.y_loc_sw <= {1'b0, body_y[tail_ptr]};
                            state        <= ERASE_TAIL;
                        end
                    end else begin
                        scan_ptr <= scan_ptr + 1'b1;
                    end
                end
                ERASE_TAIL: begin
                    tail_ptr        <= tail_ptr + 1'b1;
                    bus.writeEnable <= 1'b1;
                    bus.data_in     <= 2'b10;
                    bus.x_loc_sw    <= {1'b0, head_x};
                    bus.y_loc_sw    <= {1'b0, head_y};
                    state           <= WRITE_HEAD;
                end
                WRITE_HEAD: begin
                    head_ptr                 <= head_ptr + 1'b1;
                    body_x[head_ptr + 1'b1]  <= head_x;
                    body_y[head_ptr + 1'b1]  <= head_y;
                    if (eat) len <= len + 1'b1;
                    if (hit) begin
                        if (bus.score != 8'hFF) bus.score <= bus.score + 8'd1;
                        state <= FOOD_PICK;
                    end else begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                FOOD_PICK: if (lfsr[3:0] != 4'd0 && lfsr[7:4] != 4'd0) begin
                    cand_x   <= lfsr[3:0];
                    cand_y   <= lfsr[7:4];
                    scan_ptr <= tail_ptr;
                    state    <= FOOD_SCAN;
                end
                FOOD_SCAN: begin
                    if (cand_hit) begin
                        state <= FOOD_PICK;
                    end else if (scan_ptr == head_ptr) begin
                        food_x          <= cand_x;
                        food_y          <= cand_y;
                        bus.writeEnable <= 1'b1;
                        bus.data_in     <= 2'b01;
                        bus.x_loc_sw    <= {1'b0, cand_x};
                        bus.y_loc_sw    <= {1'b0, cand_y};
                        state           <= FOOD_WRITE;
                    end else begin
                        scan_ptr <= scan_ptr + 1'b1;
                    end
                end
                FOOD_WRITE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                DEAD: begin
                    bus.busy      <= 1'b0;
                    bus.game_over <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snake_engine.sv
// Directed and random moves checked against a queue-based snake model.
module tb_snake_engine;
    localparam int MAXL = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snake_if bus();
    snake_engine #(.MAX_LEN(MAXL), .INIT_LEN(3), .LFSR_SEED(8'hA5)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct { int x; int y; int d; } wr_t;

    int   errors = 0;
    int   checks = 0;
    int   bx[$], by[$];
    int   m_dir, fx, fy, m_score, m_dead;
    wr_t  obs_w[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int dx(input int d); return (d == 1) ? 1 : ((d == 3) ? -1 : 0); endfunction
    function automatic int dy(input int d); return (d == 2) ? 1 : ((d == 0) ? -1 : 0); endfunction
    function automatic int in_grid(input int x, input int y);
        return (x >= 1 && x <= 15 && y >= 1 && y <= 15) ? 1 : 0;
    endfunction
    function automatic int on_body(input int x, input int y, input int from);
        for (int i = from; i < bx.size(); i++)
            if (bx[i] == x && by[i] == y) return 1;
        return 0;
    endfunction

    task automatic model_reset;
        bx = '{1, 2, 3}; by = '{1, 1, 1};
        m_dir = 1; fx = 11; fy = 4; m_score = 0; m_dead = 0;
    endtask

    task automatic do_reset;
        @(negedge clk); rst = 1'b1; bus.tick = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic move(input logic [1:0] d);
        int  nd, nx, ny, hit, eat, ok, len0, n, exp_busy;
        wr_t ew[$];
        wr_t f;
        len0 = bx.size(); hit = 0; eat = 0; ok = 0; exp_busy = -1;
        if (m_dead) begin
            exp_busy = 0;
        end else begin
            nd = (int'(d) == (m_dir ^ 2)) ? m_dir : int'(d);
            nx = bx[len0-1] + dx(nd);
            ny = by[len0-1] + dy(nd);
            m_dir = nd;
            if (!in_grid(nx, ny)) begin
                m_dead = 1; exp_busy = 1;
            end else begin
                hit = (nx == fx && ny == fy) ? 1 : 0;
                eat = (hit == 1 && len0 < MAXL) ? 1 : 0;
                if (on_body(nx, ny, eat ? 0 : 1) == 1) begin
                    m_dead = 1;
                end else begin
                    ok = 1;
                    if (eat == 0) begin
                        ew.push_back('{bx[0], by[0], 0});
                        void'(bx.pop_front()); void'(by.pop_front());
                    end
                    ew.push_back('{nx, ny, 2});
                    bx.push_back(nx); by.push_back(ny);
                    if (hit == 1) begin
                        if (m_score < 255) m_score++;
                    end else exp_busy = len0 + 2;
                end
            end
        end
        @(negedge clk); bus.tick = 1'b1; bus.dir_in = d;
        @(negedge clk); bus.tick = 1'b0; bus.dir_in = 2'($urandom);
        obs_w.delete(); n = 0;
        while (bus.busy === 1'b1 && n < 3000) begin
            if (bus.writeEnable === 1'b1)
                obs_w.push_back('{int'(bus.x_loc_sw), int'(bus.y_loc_sw), int'(bus.data_in)});
            n++;
            @(negedge clk);
        end
        chk("busy_bounded", (n < 3000) ? 1 : 0, 1);
        chk("we_after_busy", bus.writeEnable, 0);
        if (exp_busy >= 0) chk("busy_cycles", n, exp_busy);
        chk("n_writes", obs_w.size(), ew.size() + ((ok == 1 && hit == 1) ? 1 : 0));
        for (int i = 0; i < ew.size() && i < obs_w.size(); i++)
            chk($sformatf("write%0d", i),
                (obs_w[i].x << 16) | (obs_w[i].y << 8) | obs_w[i].d,
                (ew[i].x << 16) | (ew[i].y << 8) | ew[i].d);
        if (ok == 1 && hit == 1 && obs_w.size() == ew.size() + 1) begin
            f = obs_w[ew.size()];
            chk("food_data", f.d, 1);
            chk("food_in_grid", in_grid(f.x, f.y), 1);
            chk("food_off_body", on_body(f.x, f.y, 0), 0);
            fx = f.x; fy = f.y;
        end
        chk("game_over", bus.game_over, m_dead);
        chk("score", bus.score, m_score);
    endtask

    function automatic logic [1:0] pick_dir(input int tx, input int ty);
        int hx, hy, c, off;
        int cand[6];
        hx = bx[bx.size()-1]; hy = by[by.size()-1];
        off = int'($urandom_range(0, 3));
        cand[0] = (tx > hx) ? 1 : ((tx < hx) ? 3 : -1);
        cand[1] = (ty > hy) ? 2 : ((ty < hy) ? 0 : -1);
        for (int i = 0; i < 4; i++) cand[i+2] = (i + off) % 4;
        for (int i = 0; i < 6; i++) begin
            c = cand[i];
            if (c >= 0 && c != (m_dir ^ 2) && in_grid(hx + dx(c), hy + dy(c)) == 1 &&
                on_body(hx + dx(c), hy + dy(c), 1) == 0)
                return 2'(c);
        end
        return 2'(m_dir);
    endfunction

    task automatic go_first_food;
        repeat (7) move(2'd1);
        repeat (3) move(2'd2);
        move(2'd1);
    endtask

    // Three quarter-turns in one rotational sense bring the head back beside its own neck.
    task automatic u_turn;
        int d, hx, hy, s;
        d = m_dir; hx = bx[bx.size()-1]; hy = by[by.size()-1];
        s = (in_grid(hx + dx((d+1)%4), hy + dy((d+1)%4)) == 1 &&
             in_grid(hx + dx((d+1)%4) + dx((d+2)%4), hy + dy((d+1)%4) + dy((d+2)%4)) == 1) ? 1 : 3;
        move(2'((d + s) % 4));
        move(2'((d + 2*s) % 4));
        move(2'((d + 3*s) % 4));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.tick = 1'b0; bus.dir_in = 2'd0;
        model_reset();
        @(negedge clk);
        chk("rst_we", bus.writeEnable, 0);
        chk("rst_data", bus.data_in, 0);
        chk("rst_x", bus.x_loc_sw, 0);
        chk("rst_y", bus.y_loc_sw, 0);
        chk("rst_score", bus.score, 0);
        chk("rst_game_over", bus.game_over, 0);
        chk("rst_busy", bus.busy, 0);
        @(negedge clk); rst = 1'b0;

        move(2'd1);
        do_reset(); move(2'd3);

        do_reset(); go_first_food();
        for (int i = 0; i < 20; i++) move(2'((i % 4 == 0) ? 2 : (i % 4 == 1) ? 3 : (i % 4 == 2) ? 0 : 1));

        // Abort in the middle of a body scan.
        @(negedge clk); bus.tick = 1'b1; bus.dir_in = 2'(m_dir);
        @(negedge clk); bus.tick = 1'b0;
        @(negedge clk);
        chk("mid_busy", bus.busy, 1);
        chk("mid_score", bus.score, m_score);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_score", bus.score, 0);
        chk("arst_we", bus.writeEnable, 0);
        chk("arst_xy", {bus.x_loc_sw, bus.y_loc_sw, bus.data_in}, 0);
        chk("arst_game_over", bus.game_over, 0);
        @(negedge clk); rst = 1'b0; model_reset();

        move(2'd0);
        move(2'd1);

        do_reset(); go_first_food();
        for (int i = 0; i < 300 && m_dead == 0 && bx.size() < 5; i++) move(pick_dir(fx, fy));
        if (m_dead == 0) u_turn();
        move(2'd2);

        do_reset();
        for (int i = 0; i < 80; i++) begin
            move(2'($urandom_range(0, 3)));
            if (m_dead == 1) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/snake_engine.md
Name: snake_engine

Overview:
Game-logic stage that sits directly upstream of the 15x15 world memory and drives its software write port (data_in, x_loc_sw, y_loc_sw, writeEnable).
- Holds the snake body as a circular coordinate buffer plus the current food location.
- On each move tick it advances the head, checks for wall or self collision, and detects food.
- It then issues single-cycle cell writes: 00 world, 01 food, 10 snake.

Parameters:
MAX_LEN, 32, body buffer depth and maximum snake length (power of 2)
INIT_LEN, 3, snake length after reset
LFSR_SEED, 8'hA5, food LFSR reset value (must be nonzero)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
tick  in  1  move strobe, one clk wide
dir_in  in  2  requested direction: 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1)
data_in  out  2  cell value to write to memory
x_loc_sw  out  5  write column, 1..15
y_loc_sw  out  5  write row, 1..15
writeEnable  out  1  one-cycle write strobe
score  out  8  food eaten, saturates at 255
game_over  out  1  sticky collision flag
busy  out  1  high while a move is in progress

Behaviour:
- Coordinates are 1-based, 1..15 on both axes. Writes go only to in-range cells.
- Reset, asynchronous, all outputs:
  - Outputs: writeEnable=0, data_in=0, x_loc_sw=0, y_loc_sw=0, score=0, game_over=0, busy=0.
  - Body: tail (1,1), (2,1), head (3,1); length=3; direction=right.
  - Food: (11,4). LFSR=LFSR_SEED. FSM=IDLE.
  - The engine issues no writes for this initial layout.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Shifts every clk, including in IDLE.
- FSM states: IDLE, COMPUTE, SCAN, ERASE_TAIL, WRITE_HEAD, FOOD_PICK, FOOD_SCAN, FOOD_WRITE, DEAD.
- IDLE:
  - tick=1 and game_over=0: latch dir_in and go to COMPUTE; busy rises the next cycle.
  - tick in any other state is ignored; no queuing.
- COMPUTE:
  - If the latched dir_in is the exact reverse of the current direction, keep the current direction. Otherwise adopt it.
  - Form next head.
  - If next x or y would be 0 or 16, go to DEAD.
  - eat = (next head == food) and length < MAX_LEN.
  - Go to SCAN.
- SCAN:
  - Compare next head against one body entry per cycle, from the entry after the tail up to the head.
  - When eat=1, the tail entry is also compared.
  - Any match goes to DEAD. Otherwise go to ERASE_TAIL if eat=0, or WRITE_HEAD if eat=1.
  - Moving into the cell being vacated by the tail is legal.
- ERASE_TAIL: write 00 at the tail cell and advance the tail pointer.
- WRITE_HEAD:
  - Write 10 at the new head and push it into the buffer.
  - eat=1: length+1, score+1 (saturating), go to FOOD_PICK.
  - eat=0: go to IDLE.
  - Tail is always erased before head is written, so a head entering the old tail cell stays 10.
- Food at MAX_LEN: with length==MAX_LEN, stepping onto food is a plain move. Score still increments, food is re-placed via FOOD_PICK, and the tail is erased.
- FOOD_PICK:
  - Candidate x=lfsr[3:0], y=lfsr[7:4].
  - If either field is 0, retry next cycle. Otherwise go to FOOD_SCAN.
- FOOD_SCAN:
  - Compare the candidate against every body entry, one per cycle.
  - A match returns to FOOD_PICK. Otherwise latch food and go to FOOD_WRITE.
- FOOD_WRITE: write 01 at food, go to IDLE.
- DEAD:
  - game_over=1, busy=0. No further writes.
  - Only rst exits.
- Write strobe: writeEnable is high for exactly one cycle per write. data_in, x_loc_sw and y_loc_sw are valid in that same cycle and hold their last value otherwise.
- busy is high from the cycle after the accepted tick through the cycle of the final write. It is low in the cycle the FSM returns to IDLE.
- Latency, non-eat move of length L: COMPUTE 1 + SCAN (L-1) + ERASE 1 + WRITE 1 = L+2 cycles.
- Reset mid-move: asynchronous abort to the reset state. Any partially written memory state is repaired by the memory's own reset, which shares rst.

Test Plan:
- Reset then tick with dir_in=01 → writes (1,1)=00, then (4,1)=10; busy high 5 cycles; score=0.
- From reset, tick with dir_in=11 (reverse) → treated as right; same two writes as above.
- Move the head to (10,4), then tick right → head (11,4)=10, no tail erase; length=4, score=1. A single 01 write follows at an LFSR cell that is not on the body, with x,y in 1..15.
- From reset, tick with dir_in=00 (head (3,1) to y=0) → no writes, game_over=1. A further tick produces no writes.
- Grow to length 5 and steer the head into its own body → DEAD with no write at the collision cell. Then assert rst asynchronously mid-SCAN on another run → all outputs return to reset values immediately.
- Length-4 snake circling a 2x2 square → head enters the vacated tail cell each move. Erase precedes head write and game_over stays 0 for 20 ticks.
